// File: rtl/bus_4b5b_pkg.sv
// Shared 4B5B symbol definitions and decoder for the NRZI/4B5B bus link.
package bus_4b5b_pkg;

  // Control symbols
  localparam logic [4:0] SYM_J    = 5'b11000;
  localparam logic [4:0] SYM_K    = 5'b10001;
  localparam logic [4:0] SYM_T    = 5'b01101;
  localparam logic [4:0] SYM_IDLE = 5'b11111;

  // Type codes, matching the {valid, is_t} bits of a decoded symbol
  localparam logic [1:0] TYPE_INV  = 2'b00;
  localparam logic [1:0] TYPE_DATA = 2'b10;
  localparam logic [1:0] TYPE_T    = 2'b11;

  typedef struct packed {
    logic       valid;
    logic       is_t;
    logic [3:0] nibble;
  } sym_dec_t;

  // Map a 5B code to {valid, is_t, nibble}; J, K, IDLE and unused codes are invalid
  function automatic sym_dec_t decode_5b4b(input logic [4:0] sym);
    sym_dec_t r;
    r.valid  = 1'b1;
    r.is_t   = 1'b0;
    r.nibble = 4'h0;
    case (sym)
      5'b11110: r.nibble = 4'h0;
      5'b01001: r.nibble = 4'h1;
      5'b10100: r.nibble = 4'h2;
      5'b10101: r.nibble = 4'h3;
      5'b01010: r.nibble = 4'h4;
      5'b01011: r.nibble = 4'h5;
      5'b01110: r.nibble = 4'h6;
      5'b01111: r.nibble = 4'h7;
      5'b10010: r.nibble = 4'h8;
      5'b10011: r.nibble = 4'h9;
      5'b10110: r.nibble = 4'hA;
      5'b10111: r.nibble = 4'hB;
      5'b11010: r.nibble = 4'hC;
      5'b11011: r.nibble = 4'hD;
      5'b11100: r.nibble = 4'hE;
      5'b11101: r.nibble = 4'hF;
      SYM_T:    r.is_t   = 1'b1;
      default:  r.valid  = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rx_4b5b_deframer_if.sv
// Line-side input and byte-side output bundle of the 4B5B deframer.
interface rx_4b5b_deframer_if #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned CNTW   = 11
);

  logic              rx;
  logic              rx_bit_en;
  logic [DWIDTH-1:0] data_out;
  logic              data_valid;
  logic              rx_frame;
  logic              frame_end;
  logic              code_err;
  logic [CNTW-1:0]   byte_cnt;

  // Deframer side
  modport master (
    input  rx, rx_bit_en,
    output data_out, data_valid, rx_frame, frame_end, code_err, byte_cnt
  );

  // Line driver / byte consumer side
  modport slave (
    output rx, rx_bit_en,
    input  data_out, data_valid, rx_frame, frame_end, code_err, byte_cnt
  );

endinterface

// File: rtl/nrzi_decoder.sv
// NRZI line decoder with in-frame zero-run detection.
module nrzi_decoder #(
  parameter int unsigned ZRUN_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic rx_i,
  input  logic bit_en_i,
  input  logic zrun_en_i,
  output logic dbit_o,
  output logic zrun_hit_o
);

  localparam int unsigned ZW = $clog2(ZRUN_MAX + 1);

  logic          rx_prev_q, rx_prev_d;
  logic [ZW-1:0] zcnt_q, zcnt_d;

  // Decode the current bit and count consecutive zeros while a frame is open
  always_comb begin
    dbit_o     = rx_i ^ rx_prev_q;
    rx_prev_d  = bit_en_i ? rx_i : rx_prev_q;
    zrun_hit_o = bit_en_i && zrun_en_i && !dbit_o && (zcnt_q == ZW'(ZRUN_MAX - 1));
    zcnt_d     = zcnt_q;
    if (!zrun_en_i) begin
      zcnt_d = '0;
    end else if (bit_en_i) begin
      // A hit restarts the count; the frame is being aborted anyway
      zcnt_d = (dbit_o || zrun_hit_o) ? '0 : zcnt_q + ZW'(1);
    end
  end

  // Previous line level (idle line is 1) and zero-run counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_prev_q <= 1'b1;
      zcnt_q    <= '0;
    end else begin
      rx_prev_q <= rx_prev_d;
      zcnt_q    <= zcnt_d;
    end
  end

endmodule

// File: rtl/rx_4b5b_deframer.sv
// 4B5B receive deframer: J/K hunt, symbol-pair to byte assembly, T/T end detection.
module rx_4b5b_deframer
  import bus_4b5b_pkg::*;
#(
  parameter int unsigned DWIDTH   = 8,
  parameter int unsigned CNTW     = 11,
  parameter int unsigned ZRUN_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  rx_4b5b_deframer_if.master    bus
);

  typedef enum logic [1:0] {StHunt, StSym1, StSym2} state_e;

  localparam int unsigned NW = DWIDTH / 2;

  state_e            state_q, state_d;
  logic [9:0]        win_q, win_d;
  logic [4:0]        sym_q, sym_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [NW-1:0]     hi_q, hi_d;
  logic              end_q, end_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic [CNTW-1:0]   byte_cnt_q, byte_cnt_d;
  logic              rx_frame_q, rx_frame_d;
  logic              data_valid_q, data_valid_d;
  logic              frame_end_q, frame_end_d;
  logic              code_err_q, code_err_d;

  logic              dbit;
  logic              zrun_hit;
  logic              zrun_en;
  logic [4:0]        sym_next;
  sym_dec_t          dec;

  assign zrun_en = (state_q != StHunt);

  nrzi_decoder #(
    .ZRUN_MAX (ZRUN_MAX)
  ) u_nrzi (
    .clk        (clk),
    .reset      (reset),
    .rx_i       (bus.rx),
    .bit_en_i   (bus.rx_bit_en),
    .zrun_en_i  (zrun_en),
    .dbit_o     (dbit),
    .zrun_hit_o (zrun_hit)
  );

  // Frame FSM: next state, byte assembly and registered output pulses
  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    sym_d        = sym_q;
    bit_cnt_d    = bit_cnt_q;
    hi_d         = hi_q;
    end_d        = end_q;
    data_d       = data_q;
    byte_cnt_d   = byte_cnt_q;
    rx_frame_d   = rx_frame_q;
    data_valid_d = 1'b0;
    frame_end_d  = 1'b0;
    code_err_d   = 1'b0;
    sym_next     = {sym_q[3:0], dbit};
    dec          = decode_5b4b(sym_next);

    if (bus.rx_bit_en) begin
      unique case (state_q)
        StHunt: begin
          // Window only moves in hunt, so a stale J/K cannot re-trigger
          win_d = {win_q[8:0], dbit};
          if (win_d == {SYM_J, SYM_K}) begin
            rx_frame_d = 1'b1;
            byte_cnt_d = '0;
            bit_cnt_d  = '0;
            end_d      = 1'b0;
            state_d    = StSym1;
          end
        end
        StSym1, StSym2: begin
          sym_d     = sym_next;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (zrun_hit) begin
            // Zero-run wins over a symbol completing on the same bit
            code_err_d = 1'b1;
            rx_frame_d = 1'b0;
            bit_cnt_d  = '0;
            state_d    = StHunt;
          end else if (bit_cnt_q == 3'd4) begin
            bit_cnt_d = '0;
            if (state_q == StSym1) begin
              if ({dec.valid, dec.is_t} == TYPE_DATA) begin
                hi_d    = dec.nibble;
                end_d   = 1'b0;
                state_d = StSym2;
              end else if ({dec.valid, dec.is_t} == TYPE_T) begin
                end_d   = 1'b1;
                state_d = StSym2;
              end else begin
                code_err_d = 1'b1;
                rx_frame_d = 1'b0;
                state_d    = StHunt;
              end
            end else begin
              if (!end_q && {dec.valid, dec.is_t} == TYPE_DATA) begin
                data_d       = {hi_q, dec.nibble};
                data_valid_d = 1'b1;
                if (byte_cnt_q != '1) begin
                  byte_cnt_d = byte_cnt_q + CNTW'(1);
                end
                state_d = StSym1;
              end else if (end_q && {dec.valid, dec.is_t} == TYPE_T) begin
                frame_end_d = 1'b1;
                rx_frame_d  = 1'b0;
                state_d     = StHunt;
              end else begin
                code_err_d = 1'b1;
                rx_frame_d = 1'b0;
                state_d    = StHunt;
              end
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StHunt;
      win_q        <= '0;
      sym_q        <= '0;
      bit_cnt_q    <= '0;
      hi_q         <= '0;
      end_q        <= 1'b0;
      data_q       <= '0;
      byte_cnt_q   <= '0;
      rx_frame_q   <= 1'b0;
      data_valid_q <= 1'b0;
      frame_end_q  <= 1'b0;
      code_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      sym_q        <= sym_d;
      bit_cnt_q    <= bit_cnt_d;
      hi_q         <= hi_d;
      end_q        <= end_d;
      data_q       <= data_d;
      byte_cnt_q   <= byte_cnt_d;
      rx_frame_q   <= rx_frame_d;
      data_valid_q <= data_valid_d;
      frame_end_q  <= frame_end_d;
      code_err_q   <= code_err_d;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = data_valid_q;
  assign bus.rx_frame   = rx_frame_q;
  assign bus.frame_end  = frame_end_q;
  assign bus.code_err   = code_err_q;
  assign bus.byte_cnt   = byte_cnt_q;

endmodule
